wb_register_file: RTL and testbench

- Write-back end of the MEM/WB pipeline register: consumes its registered outputs (write enable, result, destination selector) and commits them into a 16 x 32-bit architectural register file.
- Serves three combinational read ports to decode: Rn, Rm, and Rs/store data.
- Holds a per-register pending-write scoreboard that raises a decode stall when a source register still has an in-flight writer.
- R15 is the PC alias: reads return PC+8, writes are discarded.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/wb_scoreboard.sv | 87 ++++++++
 rtl/wb_register_file.sv | 96 +++++++++
 tb/tb_wb_register_file.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes and types for the write-back register file
package regfile_pkg;

    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 2;

    localparam logic [3:0] PC_REG = 4'd15;

    typedef logic [3:0]        reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - per-register in-flight writer counters and per-port hazard flags
module wb_scoreboard
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic       issue_we,
    input  logic [3:0] issue_dest,
    input  logic       wb_we,
    input  logic [3:0] wb_dest,
    input  logic       flush,
    input  logic [3:0] ra1,
    input  logic [3:0] ra2,
    input  logic [3:0] ra3,
    output logic       busy1,
    output logic       busy2,
    output logic       busy3,
    output logic       last1,
    output logic       last2,
    output logic       last3
);

    cnt_t cnt_q [NUM_REGS];
    cnt_t cnt_d [NUM_REGS];
    logic inc;
    logic dec;
    logic underflow;
    logic overflow;

    // Next counter values: issue adds a writer, write-back retires one; R15 never tracked.
    always_comb begin
        inc       = issue_valid & issue_we & (issue_dest != PC_REG);
        dec       = wb_we & (wb_dest != PC_REG);
        underflow = 1'b0;
        overflow  = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (inc && (issue_dest == reg_addr_t'(r)) &&
                         !(dec && (wb_dest == reg_addr_t'(r)))) begin
                if (cnt_q[r] == CNT_MAX) begin
                    overflow = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + 1'b1;
                end
            end else if (dec && (wb_dest == reg_addr_t'(r)) &&
                         !(inc && (issue_dest == reg_addr_t'(r)))) begin
                if (cnt_q[r] == '0) begin
                    underflow = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    // Counter state; reset and flush both leave every register idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Saturation only hides a bookkeeping bug upstream, so make it loud in simulation.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!underflow);
            assert (!overflow);
        end
    end

    assign busy1 = (cnt_q[ra1] != '0);
    assign busy2 = (cnt_q[ra2] != '0);
    assign busy3 = (cnt_q[ra3] != '0);

    // The last outstanding writer retiring now is covered by the bypass path.
    assign last1 = dec & (wb_dest == ra1) & (cnt_q[ra1] == cnt_t'(1));
    assign last2 = dec & (wb_dest == ra2) & (cnt_q[ra2] == cnt_t'(1));
    assign last3 = dec & (wb_dest == ra3) & (cnt_q[ra3] == cnt_t'(1));

endmodule

// File: rtl/wb_register_file.sv
// rtl/wb_register_file.sv - write-back register file with bypassed read ports and decode stall
module wb_register_file
    import regfile_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        regwBoolean,
    input  logic [31:0] FinalResult,
    input  logic [3:0]  regselectordest,
    input  logic [31:0] pc_plus8,
    input  logic [3:0]  ra1,
    input  logic [3:0]  ra2,
    input  logic [3:0]  ra3,
    input  logic        use1,
    input  logic        use2,
    input  logic        use3,
    input  logic        issue_valid,
    input  logic        issue_we,
    input  logic [3:0]  issue_dest,
    input  logic        flush,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] rd3,
    output logic        stall
);

    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];
    logic  busy1, busy2, busy3;
    logic  last1, last2, last3;

    // PC alias first, then same-cycle write-through, then stored value.
    function automatic word_t read_port(input reg_addr_t ra, input word_t stored);
        if (ra == PC_REG) begin
            return pc_plus8;
        end else if (regwBoolean && (regselectordest == ra)) begin
            return FinalResult;
        end else begin
            return stored;
        end
    endfunction

    // Commit the write-back result; R15 writes are discarded.
    always_comb begin
        regs_d = regs_q;
        if (regwBoolean && (regselectordest != PC_REG)) begin
            regs_d[regselectordest] = FinalResult;
        end
    end

    // Register array state; a flush does not block the write-back commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Three combinational read ports for decode.
    always_comb begin
        rd1 = read_port(ra1, regs_q[ra1]);
        rd2 = read_port(ra2, regs_q[ra2]);
        rd3 = read_port(ra3, regs_q[ra3]);
    end

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_dest  (issue_dest),
        .wb_we       (regwBoolean),
        .wb_dest     (regselectordest),
        .flush       (flush),
        .ra1         (ra1),
        .ra2         (ra2),
        .ra3         (ra3),
        .busy1       (busy1),
        .busy2       (busy2),
        .busy3       (busy3),
        .last1       (last1),
        .last2       (last2),
        .last3       (last3)
    );

    // Stall when a consumed source still waits on a writer that is not retiring now.
    always_comb begin
        stall = (use1 & (ra1 != PC_REG) & busy1 & ~last1) |
                (use2 & (ra2 != PC_REG) & busy2 & ~last2) |
                (use3 & (ra3 != PC_REG) & busy3 & ~last3);
    end

endmodule

// File: tb/tb_wb_register_file.sv
// tb/tb_wb_register_file.sv - self-checking bench for wb_register_file
module tb_wb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        regwBoolean;
    logic [31:0] FinalResult;
    logic [3:0]  regselectordest;
    logic [31:0] pc_plus8;
    logic [3:0]  ra1, ra2, ra3;
    logic        use1, use2, use3;
    logic        issue_valid, issue_we;
    logic [3:0]  issue_dest;
    logic        flush;
    logic [31:0] rd1, rd2, rd3;
    logic        stall;

    int total = 0;
    int bad   = 0;
    logic check_en = 1'b0;

    logic [31:0] m_regs [16];
    int          m_cnt  [16];

    always #5 clk = ~clk;

    wb_register_file dut (
        .clk             (clk),
        .reset           (reset),
        .regwBoolean     (regwBoolean),
        .FinalResult     (FinalResult),
        .regselectordest (regselectordest),
        .pc_plus8        (pc_plus8),
        .ra1             (ra1),
        .ra2             (ra2),
        .ra3             (ra3),
        .use1            (use1),
        .use2            (use2),
        .use3            (use3),
        .issue_valid     (issue_valid),
        .issue_we        (issue_we),
        .issue_dest      (issue_dest),
        .flush           (flush),
        .rd1             (rd1),
        .rd2             (rd2),
        .rd3             (rd3),
        .stall           (stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [3:0] ra);
        if (ra == 4'd15) return pc_plus8;
        if (regwBoolean && regselectordest == ra) return FinalResult;
        return m_regs[ra];
    endfunction

    // A source is a hazard when writers are outstanding, unless the only one writes back now.
    function automatic logic exp_hazard(input logic u, input logic [3:0] ra);
        int pending;
        if (!u || ra == 4'd15) return 1'b0;
        pending = m_cnt[ra];
        if (regwBoolean && regselectordest == ra) pending = pending - 1;
        return pending > 0;
    endfunction

    // Reference state advances on each rising edge from the inputs applied in that cycle.
    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 16; r++) begin
                m_regs[r] = 32'h0;
                m_cnt[r]  = 0;
            end
        end else begin
            if (regwBoolean && regselectordest != 4'd15) m_regs[regselectordest] = FinalResult;
            if (flush) begin
                for (int r = 0; r < 16; r++) m_cnt[r] = 0;
            end else begin
                if (issue_valid && issue_we && issue_dest != 4'd15) m_cnt[issue_dest] += 1;
                if (regwBoolean && regselectordest != 4'd15) m_cnt[regselectordest] -= 1;
                for (int r = 0; r < 16; r++) begin
                    if (m_cnt[r] < 0) m_cnt[r] = 0;
                    if (m_cnt[r] > 3) m_cnt[r] = 3;
                end
            end
        end
    end

    // Continuous comparison against the reference, mid-cycle.
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_rd1", rd1, exp_rd(ra1));
            chk("model_rd2", rd2, exp_rd(ra2));
            chk("model_rd3", rd3, exp_rd(ra3));
            chk("model_stall", {31'b0, stall},
                {31'b0, exp_hazard(use1, ra1) | exp_hazard(use2, ra2) | exp_hazard(use3, ra3)});
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        regwBoolean = 0; issue_valid = 0; issue_we = 0; flush = 0;
    endtask

    task automatic issue(input logic [3:0] d);
        issue_valid = 1; issue_we = 1; issue_dest = d;
    endtask

    task automatic wb(input logic [3:0] d, input logic [31:0] v);
        regwBoolean = 1; regselectordest = d; FinalResult = v;
    endtask

    initial begin
        reset = 1; idle();
        FinalResult = 0; regselectordest = 0; issue_dest = 0;
        pc_plus8 = 32'h108;
        ra1 = 0; ra2 = 0; ra3 = 0; use1 = 0; use2 = 0; use3 = 0;
        next(); next();
        reset = 0;
        check_en = 1;

        // reset state
        ra1 = 4'd3; ra2 = 4'd15; ra3 = 4'd9; use1 = 1; use2 = 1;
        settle();
        chk("reset_rd1", rd1, 32'h0);
        chk("reset_rd2_pc", rd2, 32'h108);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        next();

        // plain write with bypass
        issue(4'd5);
        next(); idle();
        wb(4'd5, 32'hDEADBEEF); ra1 = 4'd5;
        settle();
        chk("bypass_rd1", rd1, 32'hDEADBEEF);
        chk("last_retire_stall", {31'b0, stall}, 32'h0);
        next(); idle();
        settle();
        chk("stored_rd1", rd1, 32'hDEADBEEF);
        next();

        // R15 write is dropped
        wb(4'd15, 32'h1234); ra1 = 4'd15; ra2 = 4'd5;
        settle();
        chk("r15_bypass_ignored", rd1, 32'h108);
        next(); idle();
        settle();
        chk("r15_after_write", rd1, 32'h108);
        chk("r5_unchanged", rd2, 32'hDEADBEEF);
        next();

        // single-writer hazard on port 1, port 3 reading it unused
        issue(4'd2); ra1 = 4'd2; ra3 = 4'd2; use3 = 0; ra2 = 4'd0;
        settle();
        chk("hazard_issue_cycle", {31'b0, stall}, 32'h0);
        next(); idle();
        settle();
        chk("hazard_stall", {31'b0, stall}, 32'h1);
        next();
        settle();
        chk("hazard_hold", {31'b0, stall}, 32'h1);
        next();
        wb(4'd2, 32'h77);
        settle();
        chk("hazard_release", {31'b0, stall}, 32'h0);
        chk("hazard_bypass", rd1, 32'h77);
        next(); idle();
        settle();
        chk("hazard_cleared", {31'b0, stall}, 32'h0);
        next();

        // double writer with simultaneous issue and write-back on R4
        issue(4'd4); next(); next(); idle();
        ra1 = 4'd4;
        issue(4'd4); wb(4'd4, 32'h40);
        settle();
        chk("dual_same_cycle", {31'b0, stall}, 32'h1);
        next(); idle();
        wb(4'd4, 32'h41);
        settle();
        chk("dual_cnt2", {31'b0, stall}, 32'h1);
        next();
        wb(4'd4, 32'h42);
        settle();
        chk("dual_last", {31'b0, stall}, 32'h0);
        chk("dual_bypass", rd1, 32'h42);
        next(); idle();
        settle();
        chk("dual_done", {31'b0, stall}, 32'h0);
        chk("dual_stored", rd1, 32'h42);
        next();

        // port 2 hazard, then flush with a committed write-back and a discarded issue
        issue(4'd8); next();
        issue(4'd6); next(); next(); idle();
        ra1 = 4'd6; ra2 = 4'd8; use2 = 1;
        settle();
        chk("pre_flush_stall", {31'b0, stall}, 32'h1);
        next();
        flush = 1; wb(4'd8, 32'h88); issue(4'd9);
        next(); idle();
        ra2 = 4'd9; ra3 = 4'd8; use3 = 1;
        settle();
        chk("flush_stall", {31'b0, stall}, 32'h0);
        chk("flush_wb_commit", rd3, 32'h88);
        next();

        // reset mid-operation drops the same-cycle write
        issue(4'd7); next(); idle();
        reset = 1; wb(4'd7, 32'h7777);
        next();
        reset = 0; idle(); ra1 = 4'd7; ra2 = 4'd4;
        settle();
        chk("reset_drops_wb", rd1, 32'h0);
        chk("reset_clears_regs", rd2, 32'h0);
        chk("reset_clears_cnt", {31'b0, stall}, 32'h0);
        next();

        check_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
